// File: rtl/dm_pkg.sv
// dm_pkg: access-size and FSM-state encodings shared by the data memory files
package dm_pkg;
  localparam logic [1:0] DM_BYTE = 2'b00;
  localparam logic [1:0] DM_HALF = 2'b01;
  localparam logic [1:0] DM_WORD = 2'b10;
  typedef enum logic {DM_IDLE, DM_CLEAR} dm_state_e;
endpackage

// File: rtl/data_memory_ext_if.sv
// dm_if: datapath-to-data-memory bus
// master = datapath (drives address, data, controls); slave = memory (drives load result and status)
interface dm_if;
  logic [31:0] dm_addr;
  logic [31:0] dm_write_data;
  logic        ctrl_dataMem_Write;
  logic        ctrl_dataMem2reg;
  logic [1:0]  dm_size;
  logic        dm_unsigned;
  logic [31:0] dm_read_data;
  logic        dm_busy;
  logic        dm_misaligned;
  logic        dm_out_of_range;
  logic        dm_err_sticky;
  modport master (
    output dm_addr, dm_write_data, ctrl_dataMem_Write, ctrl_dataMem2reg, dm_size, dm_unsigned,
    input  dm_read_data, dm_busy, dm_misaligned, dm_out_of_range, dm_err_sticky
  );
  modport slave (
    input  dm_addr, dm_write_data, ctrl_dataMem_Write, ctrl_dataMem2reg, dm_size, dm_unsigned,
    output dm_read_data, dm_busy, dm_misaligned, dm_out_of_range, dm_err_sticky
  );
endinterface

// File: rtl/dm_lane_align.sv
// dm_lane_align: little-endian lane select/extend for loads, lane mask and replicated data for stores
// in:  lane (addr[1:0]), size, uns (zero-extend), rword (addressed word), wdata (store data)
// out: rdata (extended load value), wmask (lanes to write), wword (store data replicated across lanes)
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wword
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rword[{lane, 3'b000} +: 8];
    h = lane[1] ? rword[31:16] : rword[15:0];
    rdata = size == DM_BYTE ? {{24{~uns & b[7]}}, b}
          : size == DM_HALF ? {{16{~uns & h[15]}}, h} : rword;
    wmask = size == DM_BYTE ? 4'b0001 << lane
          : size == DM_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wword = size == DM_BYTE ? {4{wdata[7:0]}}
          : size == DM_HALF ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/data_memory_ext.sv
// data_memory_ext: byte/half/word data memory with range/alignment checks and sequenced clear
// clk, rst_dm (sync, active-high); bus (dm_if.slave): address, store data, write/load controls,
// size, unsigned -> load data (or address passthrough), busy, misaligned, out-of-range, sticky error
module data_memory_ext
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS    = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic clk,
  input  logic rst_dm,
  dm_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  dm_state_e state, state_nxt;
  logic [IDX_W-1:0] ptr, idx;
  logic acc, busy, is_word, err, store;
  logic [31:0] lane_rdata, wword;
  logic [3:0] wmask;
  assign idx     = bus.dm_addr[IDX_W+1:2];
  assign acc     = bus.ctrl_dataMem_Write | bus.ctrl_dataMem2reg;
  assign busy    = state == DM_CLEAR;
  assign is_word = bus.dm_size != DM_BYTE && bus.dm_size != DM_HALF;
  assign bus.dm_misaligned   = acc & (bus.dm_size == DM_HALF ? bus.dm_addr[0] : is_word & |bus.dm_addr[1:0]);
  assign bus.dm_out_of_range = acc & |bus.dm_addr[31:IDX_W+2];
  assign err     = bus.dm_misaligned | bus.dm_out_of_range;
  assign store   = bus.ctrl_dataMem_Write & ~err & ~busy;
  assign bus.dm_busy = busy;
  assign bus.dm_read_data = !bus.ctrl_dataMem2reg ? bus.dm_addr : (err | busy) ? '0 : lane_rdata;
  dm_lane_align u_align (
    .lane  (bus.dm_addr[1:0]),
    .size  (bus.dm_size),
    .uns   (bus.dm_unsigned),
    .rword (mem[idx]),
    .wdata (bus.dm_write_data),
    .rdata (lane_rdata),
    .wmask (wmask),
    .wword (wword)
  );
  always_comb state_nxt = (busy && ptr == IDX_W'(DEPTH_WORDS - 1)) ? DM_IDLE : state;
  always_ff @(posedge clk) begin
    if (rst_dm) begin
      state <= CLEAR_ON_RESET ? DM_CLEAR : DM_IDLE;
      ptr   <= '0;
      bus.dm_err_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= busy ? ptr + 1'b1 : ptr;
      bus.dm_err_sticky <= bus.dm_err_sticky | err;
    end
  end
  // The array itself has no reset; contents survive reset unless the clear sequence runs.
  always_ff @(posedge clk) begin
    if (!rst_dm) begin
      if (busy) mem[ptr] <= '0;
      else if (store)
        for (int i = 0; i < 4; i++)
          if (wmask[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end
  end
endmodule
